// File: rtl/tap_acc_pkg.sv
// Shared types, default sizes and the saturating adder for the tap accumulator.
package tap_acc_pkg;

  localparam int unsigned DEF_NTAPS = 8;
  localparam int unsigned DEF_PW    = 1;
  localparam int unsigned DEF_ACC_W = 4;
  localparam int unsigned CNT_W     = $clog2(DEF_NTAPS);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_e;

  typedef struct packed {
    logic [DEF_ACC_W-1:0] sum;
    logic                 sat;
  } fifo_entry_t;

  // Unsigned add clamped to w bits (w < 32); returns {clamped, value}.
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] full_sum;
    logic [31:0] max_val;
    max_val  = (32'd1 << w) - 32'd1;
    full_sum = {1'b0, a} + {1'b0, b};
    if (full_sum > {1'b0, max_val}) begin
      return {1'b1, max_val};
    end
    return {1'b0, full_sum[31:0]};
  endfunction

endpackage

// File: rtl/tap_accumulator_if.sv
// Product input and frame-sum output handshakes of the tap accumulator.
interface tap_accumulator_if
  import tap_acc_pkg::*;
#(
  parameter int unsigned PW    = DEF_PW,
  parameter int unsigned ACC_W = DEF_ACC_W
) ();

  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    in_prod;
  logic             in_first;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_sat;
  logic             err_seq;

  modport master (
    output in_valid, in_prod, in_first, out_ready,
    input  in_ready, out_valid, out_sum, out_sat, err_seq
  );

  modport slave (
    input  in_valid, in_prod, in_first, out_ready,
    output in_ready, out_valid, out_sum, out_sat, err_seq
  );

endinterface

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO; the head entry is always presented on o_data.
module sync_fifo2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  logic [Width-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/tap_accumulator.sv
// Frame-aligned saturating accumulator of FIR tap products with a 2-deep result FIFO.
module tap_accumulator
  import tap_acc_pkg::*;
#(
  parameter int unsigned NTAPS = DEF_NTAPS,
  parameter int unsigned PW    = DEF_PW,
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input logic              clk,
  input logic              rst,
  tap_accumulator_if.slave bus
);

  localparam int unsigned CntW = $clog2(NTAPS);
  localparam int unsigned EntW = ACC_W + 1;

  state_e           r_state;
  logic [CntW-1:0]  r_tap_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_sat;
  logic             r_err;

  logic             w_fire;
  logic             w_last;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic             w_ovf;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W-1:0] w_sum;
  logic [32:0]      w_add;
  logic [EntW-1:0]  w_head;
  logic             w_unused_add;

  // A beat flagged in_first always starts from zero, even when it aborts a partial frame.
  always_comb begin
    w_fire = bus.in_valid && !w_full;
    w_base = ((r_state == ACCUM) && !bus.in_first) ? r_acc : '0;
    w_add  = sat_add(32'(w_base), 32'(bus.in_prod), ACC_W);
    w_sum  = w_add[ACC_W-1:0];
    w_ovf  = w_add[32];
    w_last = (r_state == ACCUM) && !bus.in_first && (r_tap_cnt == CntW'(NTAPS - 1));
    w_push = w_fire && w_last;
  end

  assign w_unused_add = ^w_add[31:ACC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tap_cnt <= '0;
      r_acc     <= '0;
      r_sat     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_fire) begin
        case (r_state)
          IDLE: begin
            if (bus.in_first) begin
              r_acc     <= w_sum;
              r_sat     <= w_ovf;
              r_tap_cnt <= CntW'(1);
              r_state   <= ACCUM;
            end else begin
              r_err <= 1'b1;
            end
          end
          ACCUM: begin
            if (bus.in_first) begin
              r_err     <= 1'b1;
              r_acc     <= w_sum;
              r_sat     <= w_ovf;
              r_tap_cnt <= CntW'(1);
            end else if (w_last) begin
              r_tap_cnt <= '0;
              r_state   <= IDLE;
            end else begin
              r_acc     <= w_sum;
              r_sat     <= r_sat | w_ovf;
              r_tap_cnt <= r_tap_cnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  sync_fifo2 #(
    .Width(EntW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_data ({w_sum, r_sat | w_ovf}),
    .i_pop  (bus.out_ready),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign bus.in_ready  = !w_full;
  assign bus.out_valid = !w_empty;
  assign bus.out_sum   = w_head[EntW-1:1];
  assign bus.out_sat   = w_head[0];
  assign bus.err_seq   = r_err;

endmodule

// File: tb/tb_tap_accumulator.sv
// Directed bench: a 4-bit accumulator plus a 2-bit one fed identical stimulus for clamping.
module tb_tap_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tap_accumulator_if #(.PW(1), .ACC_W(4)) bus ();
  tap_accumulator_if #(.PW(1), .ACC_W(2)) bus_s ();

  tap_accumulator #(.NTAPS(8), .PW(1), .ACC_W(4)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  tap_accumulator #(.NTAPS(8), .PW(1), .ACC_W(2)) u_dut_sat (
    .clk(clk),
    .rst(rst),
    .bus(bus_s)
  );

  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.in_prod   = bus.in_prod;
  assign bus_s.in_first  = bus.in_first;
  assign bus_s.out_ready = bus.out_ready;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  logic [4:0] q_main[$];
  logic [2:0] q_sat[$];

  // Popped entries and error pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) q_main.push_back({bus.out_sum, bus.out_sat});
    if (!rst && bus_s.out_valid && bus_s.out_ready) q_sat.push_back({bus_s.out_sum, bus_s.out_sat});
    if (!rst && bus.err_seq) err_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic p, input logic f);
    logic acc;
    int   n;
    acc          = 1'b0;
    n            = 0;
    bus.in_valid = 1'b1;
    bus.in_prod  = p;
    bus.in_first = f;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check_eq("accept_timeout", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_beat(v[i], i == 0);
  endtask

  task automatic clear_queues();
    q_main.delete();
    q_sat.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] alt;
    alt           = 8'h55;
    bus.in_valid  = 1'b0;
    bus.in_prod   = 1'b0;
    bus.in_first  = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    wait_cycles(2);
    rst = 1'b0;

    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_sum", 32'(bus.out_sum), 32'd0);
    check_eq("rst_out_sat", 32'(bus.out_sat), 32'd0);
    check_eq("rst_err_seq", 32'(bus.err_seq), 32'd0);

    // Nominal frame 1,0,1,0,1,0,1,0
    for (int i = 0; i < 7; i++) send_beat(alt[i], i == 0);
    check_eq("nom_no_early_valid", 32'(bus.out_valid), 32'd0);
    send_beat(alt[7], 1'b0);
    check_eq("nom_valid", 32'(bus.out_valid), 32'd1);
    check_eq("nom_sum", 32'(bus.out_sum), 32'd4);
    check_eq("nom_sat", 32'(bus.out_sat), 32'd0);
    check_eq("nom_sum_w2", 32'(bus_s.out_sum), 32'd3);
    check_eq("nom_sat_w2", 32'(bus_s.out_sat), 32'd1);
    wait_cycles(3);
    check_eq("nom_no_err", 32'(err_cnt), 32'd0);
    clear_queues();

    // Saturation, then an all-zero frame clears the flag
    send_frame(8'hFF);
    send_frame(8'h00);
    wait_cycles(3);
    check_eq("sat_q_size", 32'(q_sat.size()), 32'd2);
    if (q_sat.size() == 2) begin
      check_eq("sat_frame_ones", 32'(q_sat[0]), 32'({2'd3, 1'b1}));
      check_eq("sat_frame_zeros", 32'(q_sat[1]), 32'd0);
    end
    check_eq("wide_q_size", 32'(q_main.size()), 32'd2);
    if (q_main.size() == 2) begin
      check_eq("wide_frame_ones", 32'(q_main[0]), 32'({4'd8, 1'b0}));
      check_eq("wide_frame_zeros", 32'(q_main[1]), 32'd0);
    end
    clear_queues();

    // Backpressure: three frames against a stalled consumer
    bus.out_ready = 1'b0;
    send_frame(8'hFF);
    send_frame(8'hFF);
    check_eq("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    fork
      send_frame(8'hFF);
      begin
        wait_cycles(5);
        check_eq("bp_stall_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("bp_stall_no_pop", 32'(q_main.size()), 32'd0);
        check_eq("bp_head_held", 32'(bus.out_sum), 32'd8);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #2;
        check_eq("bp_ready_after_pop", 32'(bus.in_ready), 32'd1);
      end
    join
    wait_cycles(4);
    check_eq("bp_q_size", 32'(q_main.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (q_main.size() > i) check_eq("bp_entry", 32'(q_main[i]), 32'({4'd8, 1'b0}));
    end
    check_eq("bp_no_err", 32'(err_cnt), 32'd0);
    clear_queues();

    // Framing errors
    err_cnt = 0;
    send_beat(1'b1, 1'b0);
    check_eq("fe_idle_pulse", 32'(bus.err_seq), 32'd1);
    wait_cycles(1);
    check_eq("fe_pulse_one_cycle", 32'(bus.err_seq), 32'd0);
    send_beat(1'b1, 1'b1);
    send_beat(1'b1, 1'b0);
    send_beat(1'b1, 1'b0);
    send_beat(1'b1, 1'b1);
    check_eq("fe_restart_pulse", 32'(bus.err_seq), 32'd1);
    for (int i = 0; i < 7; i++) send_beat(1'b1, 1'b0);
    wait_cycles(3);
    check_eq("fe_q_size", 32'(q_main.size()), 32'd1);
    if (q_main.size() == 1) check_eq("fe_restart_sum", 32'(q_main[0]), 32'({4'd8, 1'b0}));
    check_eq("fe_err_count", 32'(err_cnt), 32'd2);
    clear_queues();

    // Reset mid-frame with one entry queued
    bus.out_ready = 1'b0;
    send_frame(8'hFF);
    send_beat(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send_beat(1'b1, 1'b0);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_prod  = 1'b1;
    wait_cycles(1);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("rm_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rm_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rm_out_sum", 32'(bus.out_sum), 32'd0);
    bus.out_ready = 1'b1;
    send_frame(alt);
    wait_cycles(3);
    check_eq("rm_q_size", 32'(q_main.size()), 32'd1);
    if (q_main.size() == 1) check_eq("rm_fresh_sum", 32'(q_main[0]), 32'({4'd4, 1'b0}));
    clear_queues();

    // Push and pop in the same cycle with one entry queued
    bus.out_ready = 1'b0;
    send_frame(8'hFF);
    wait_cycles(2);
    check_eq("pp_head_valid", 32'(bus.out_valid), 32'd1);
    check_eq("pp_head_held", 32'(bus.out_sum), 32'd8);
    for (int i = 0; i < 7; i++) send_beat(alt[i], i == 0);
    bus.out_ready = 1'b1;
    send_beat(alt[7], 1'b0);
    check_eq("pp_valid_kept", 32'(bus.out_valid), 32'd1);
    check_eq("pp_new_head", 32'(bus.out_sum), 32'd4);
    check_eq("pp_in_ready", 32'(bus.in_ready), 32'd1);
    wait_cycles(3);
    check_eq("pp_q_size", 32'(q_main.size()), 32'd2);
    if (q_main.size() == 2) begin
      check_eq("pp_first_pop", 32'(q_main[0]), 32'({4'd8, 1'b0}));
      check_eq("pp_second_pop", 32'(q_main[1]), 32'({4'd4, 1'b0}));
    end
    check_eq("final_err_count", 32'(err_cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
